// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg
//   Shared definitions for the HPS PIO command responder: instruction word
//   field positions, opcode encodings, flag bit indices, FSM state encoding
//   and small opcode classification helpers.
package pio_cmd_pkg;

  // Instruction word layout: [2:0] op, [19:3] addr, [27:20] data, [28] reserved
  localparam int INSTR_W  = 29;
  localparam int OP_LSB   = 0;
  localparam int OP_W     = 3;
  localparam int ADDR_LSB = 3;
  localparam int DATA_LSB = 20;
  localparam int DATA_W   = 8;
  localparam int RSVD_BIT = 28;

  // Opcodes
  localparam logic [OP_W-1:0] OP_NOP      = 3'd0;
  localparam logic [OP_W-1:0] OP_WRITE    = 3'd1;
  localparam logic [OP_W-1:0] OP_READ     = 3'd2;
  localparam logic [OP_W-1:0] OP_ALGO     = 3'd3;
  localparam logic [OP_W-1:0] OP_CORE_RST = 3'd4;

  // Highest legal algorithm mode carried in data[2:0] of an ALGO command
  localparam logic [2:0] ALGO_MODE_MAX = 3'd3;

  // Bit positions inside the 4-bit flags output
  localparam int FLAG_DONE = 0;
  localparam int FLAG_BUSY = 1;
  localparam int FLAG_ALGO = 2;
  localparam int FLAG_ERR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return (op > OP_CORE_RST);
  endfunction

  // WRITE and READ are the only opcodes that touch pixel memory
  function automatic logic op_uses_addr(input logic [OP_W-1:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// pio_sync_edge
//   Multi-flop synchroniser for a level signal coming from another timing
//   domain, followed by a rising-edge detector on the synchronised level.
// Ports
//   clk      in  system clock
//   reset    in  synchronous, active-high; clears every stage
//   async_i  in  raw level to synchronise
//   level_o  out synchronised level (last stage)
//   rise_o   out one-cycle pulse when level_o goes 0 -> 1 (combinational)
module pio_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_i};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[STAGES-1];
  // Combinational so the FSM can accept on the very next edge
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pio_cmd_responder.sv
// pio_cmd_responder
//   FPGA-side end of the HPS PIO command channel. A rising edge on the
//   synchronised enable level accepts the instruction word, which is checked,
//   issued to the zoom coprocessor core as a held request, and answered with
//   result data and status flags. The HPS must lower enable before the next
//   command (four-phase handshake).
// Ports
//   clk, reset            clock, synchronous active-high reset
//   instruct[28:0]        {rsvd, data[7:0], addr[16:0], op[2:0]} from HPS
//   enable                HPS command strobe (level)
//   dataout[7:0]          last successful READ result
//   flags[3:0]            {error, algo_mode_valid, busy, done}
//   core_req              request to core, held until core_ack or timeout
//   core_op/addr/wdata    command fields, stable while core_req
//   core_ack, core_rdata  one-cycle completion and read data from core
//
// state  | meaning
// IDLE   | waiting for rising edge of synced enable
// CHECK  | one cycle of validation of the latched command
// ISSUE  | core_req held, waiting for core_ack or timeout
// DONE   | result posted, waiting for synced enable to drop
module pio_cmd_responder
  import pio_cmd_pkg::*;
#(
  parameter int ADDR_W      = 17,
  parameter int MEM_DEPTH   = 76800,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruct,
  input  logic               enable,
  output logic [DATA_W-1:0]  dataout,
  output logic [3:0]         flags,
  output logic               core_req,
  output logic [OP_W-1:0]    core_op,
  output logic [ADDR_W-1:0]  core_addr,
  output logic [DATA_W-1:0]  core_wdata,
  input  logic               core_ack,
  input  logic [DATA_W-1:0]  core_rdata
);

  // Down-counter holding the remaining ISSUE cycles after the current one
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic en_level, en_rise;

  pio_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_en_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (enable),
    .level_o (en_level),
    .rise_o  (en_rise)
  );

  state_e             state_q, state_d;
  logic [OP_W-1:0]    cmd_op_q, cmd_op_d;
  logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]  cmd_data_q, cmd_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               core_req_q, core_req_d;
  logic [DATA_W-1:0]  dataout_q, dataout_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               algo_q, algo_d;

  logic addr_oob, mode_bad, cmd_bad;
  logic unused_rsvd;

  assign unused_rsvd = instruct[RSVD_BIT];

  assign addr_oob = (32'(cmd_addr_q) >= 32'(MEM_DEPTH));
  assign mode_bad = (cmd_data_q[2:0] > ALGO_MODE_MAX);
  assign cmd_bad  = op_is_illegal(cmd_op_q)
                  || (op_uses_addr(cmd_op_q) && addr_oob)
                  || ((cmd_op_q == OP_ALGO) && mode_bad);

  always_comb begin
    state_d    = state_q;
    cmd_op_d   = cmd_op_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    cnt_d      = cnt_q;
    core_req_d = core_req_q;
    dataout_d  = dataout_q;
    err_d      = err_q;
    done_d     = done_q;
    busy_d     = busy_q;
    algo_d     = algo_q;

    case (state_q)
      ST_IDLE: begin
        if (en_rise) begin
          cmd_op_d   = instruct[OP_LSB +: OP_W];
          cmd_addr_d = instruct[ADDR_LSB +: ADDR_W];
          cmd_data_d = instruct[DATA_LSB +: DATA_W];
          done_d     = 1'b0;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (cmd_bad || (cmd_op_q == OP_NOP)) begin
          err_d   = cmd_bad;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          core_req_d = 1'b1;
          cnt_d      = CNT_W'(TIMEOUT - 1);
          state_d    = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // ack is tested first so an ack on the last allowed cycle still succeeds
        if (core_ack) begin
          core_req_d = 1'b0;
          if (cmd_op_q == OP_READ)     dataout_d = core_rdata;
          if (cmd_op_q == OP_ALGO)     algo_d    = 1'b1;
          if (cmd_op_q == OP_CORE_RST) algo_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == '0) begin
          core_req_d = 1'b0;
          err_d      = 1'b1;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (!en_level) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_op_q   <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cnt_q      <= '0;
      core_req_q <= 1'b0;
      dataout_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      algo_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_op_q   <= cmd_op_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      cnt_q      <= cnt_d;
      core_req_q <= core_req_d;
      dataout_q  <= dataout_d;
      err_q      <= err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      algo_q     <= algo_d;
    end
  end

  // Command fields come straight from the cmd register, which only changes
  // on accept, so they stay stable for the whole request.
  assign core_req   = core_req_q;
  assign core_op    = cmd_op_q;
  assign core_addr  = cmd_addr_q;
  assign core_wdata = cmd_data_q;
  assign dataout    = dataout_q;

  always_comb begin
    flags            = '0;
    flags[FLAG_DONE] = done_q;
    flags[FLAG_BUSY] = busy_q;
    flags[FLAG_ALGO] = algo_q;
    flags[FLAG_ERR]  = err_q;
  end

endmodule

// File: tb/tb_pio_cmd_responder.sv
module tb_pio_cmd_responder;
  import pio_cmd_pkg::*;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [28:0] instruct;
  logic        enable;
  logic [7:0]  dataout;
  logic [3:0]  flags;
  logic        core_req;
  logic [2:0]  core_op;
  logic [16:0] core_addr;
  logic [7:0]  core_wdata;
  logic        core_ack;
  logic [7:0]  core_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pio_cmd_responder #(
    .ADDR_W      (17),
    .MEM_DEPTH   (76800),
    .SYNC_STAGES (2),
    .TIMEOUT     (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instruct   (instruct),
    .enable     (enable),
    .dataout    (dataout),
    .flags      (flags),
    .core_req   (core_req),
    .core_op    (core_op),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_rdata (core_rdata)
  );

  // ack_dly: core_req cycles before (and including) the ack cycle; 0 = never ack
  typedef struct {
    logic [2:0]  op;
    logic [16:0] addr;
    logic [7:0]  data;
    int          ack_dly;
    logic [7:0]  rdata;
    int          exp_req;
    logic [3:0]  exp_flags;
    logic [7:0]  exp_dout;
  } vec_t;

  typedef struct {
    int          req;
    logic [3:0]  flags;
    logic [7:0]  dout;
  } exp_t;

  exp_t sb_q[$];
  vec_t vtab[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input bit drop);
    exp_t e;
    int   n, req_cnt, busy_at, req_at;
    bit   stable, got_done;
    e.req   = v.exp_req;
    e.flags = v.exp_flags;
    e.dout  = v.exp_dout;
    @(negedge clk);
    instruct = {1'b0, v.data, v.addr, v.op};
    enable   = 1'b1;
    sb_q.push_back(e);
    n = 0; req_cnt = 0; busy_at = -1; req_at = -1; stable = 1'b1; got_done = 1'b0;
    while (n < 200 && !got_done) begin
      @(negedge clk);
      n++;
      core_ack = 1'b0;
      if (busy_at < 0 && flags[FLAG_BUSY]) busy_at = n;
      if (core_req) begin
        if (req_at < 0) req_at = n;
        req_cnt++;
        if (core_op !== v.op || core_addr !== v.addr || core_wdata !== v.data) stable = 1'b0;
        instruct = 29'($urandom);
        if (req_cnt == v.ack_dly) begin
          core_ack   = 1'b1;
          core_rdata = v.rdata;
        end
      end
      if (busy_at >= 0 && flags[FLAG_DONE] && !flags[FLAG_BUSY]) got_done = 1'b1;
    end
    core_ack = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    e = sb_q.pop_front();
    check("busy_latency", 32'(busy_at), 32'd3);
    check("req_cycles", 32'(req_cnt), 32'(e.req));
    if (e.req > 0) begin
      check("req_latency", 32'(req_at), 32'd4);
      check("req_fields_stable", 32'(stable), 32'd1);
    end
    check("flags", 32'(flags), 32'(e.flags));
    check("dataout", 32'(dataout), 32'(e.dout));
    if (drop) begin
      enable = 1'b0;
      repeat (4) @(negedge clk);
      check("flags_after_drop", 32'(flags), 32'(e.flags));
    end
  endtask

  initial begin
    vec_t v;
    int   n;
    bit   seen;

    //              op           addr          data   ack rdata  req  flags    dout
    vtab[0]  = '{OP_WRITE,    17'd100,     8'hA5, 3, 8'h00, 3,   4'b0001, 8'h00};
    vtab[1]  = '{OP_READ,     17'd76799,   8'h00, 2, 8'h3C, 2,   4'b0001, 8'h3C};
    vtab[2]  = '{OP_READ,     17'd76800,   8'h00, 1, 8'h99, 0,   4'b1001, 8'h3C};
    vtab[3]  = '{3'd6,        17'd10,      8'h00, 1, 8'h99, 0,   4'b1001, 8'h3C};
    vtab[4]  = '{OP_ALGO,     17'd0,       8'h05, 1, 8'h99, 0,   4'b1001, 8'h3C};
    vtab[5]  = '{OP_ALGO,     17'd0,       8'h02, 1, 8'h00, 1,   4'b0101, 8'h3C};
    vtab[6]  = '{OP_NOP,      17'd0,       8'h00, 1, 8'h00, 0,   4'b0101, 8'h3C};
    vtab[7]  = '{OP_READ,     17'd0,       8'h00, 0, 8'h5A, TMO, 4'b1101, 8'h3C};
    vtab[8]  = '{OP_READ,     17'd5,       8'h00, 4, 8'h81, 4,   4'b0101, 8'h81};
    vtab[9]  = '{OP_CORE_RST, 17'd0,       8'h00, 2, 8'h00, 2,   4'b0001, 8'h81};
    vtab[10] = '{3'd7,        17'd0,       8'h00, 1, 8'h00, 0,   4'b1001, 8'h81};
    vtab[11] = '{OP_WRITE,    17'd76799,   8'hFF, 1, 8'h00, 1,   4'b0001, 8'h81};
    vtab[12] = '{OP_ALGO,     17'd0,       8'hFB, 1, 8'h00, 1,   4'b0101, 8'h81};

    reset = 1'b1; enable = 1'b0; instruct = '0; core_ack = 1'b0; core_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_core_req", 32'(core_req), 32'd0);
    check("rst_core_fields", 32'({core_op, core_addr, core_wdata}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vtab[i], 1'b1);

    // enable held high after done: no second command until it drops
    v = '{OP_WRITE, 17'd200, 8'h11, 2, 8'h00, 2, 4'b0101, 8'h81};
    run_vec(v, 1'b0);
    instruct = {1'b0, 8'h22, 17'd300, OP_READ};
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (core_req) seen = 1'b1;
      instruct = 29'($urandom);
    end
    check("held_no_req", 32'(seen), 32'd0);
    check("held_flags", 32'(flags), 32'b0101);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    v = '{OP_READ, 17'd300, 8'h00, 1, 8'h77, 1, 4'b0101, 8'h77};
    run_vec(v, 1'b1);

    // core_ack while idle is ignored
    core_ack = 1'b1; core_rdata = 8'hEE;
    @(negedge clk);
    core_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ack_dataout", 32'(dataout), 32'h77);
    check("idle_ack_flags", 32'(flags), 32'b0101);

    // reset in the middle of ISSUE
    instruct = {1'b0, 8'h00, 17'd7, OP_READ};
    enable   = 1'b1;
    n = 0;
    while (n < 20 && !core_req) begin
      @(negedge clk);
      n++;
    end
    check("reach_issue", 32'(core_req), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_core_req", 32'(core_req), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    check("midrst_dataout", 32'(dataout), 32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    v = '{OP_WRITE, 17'd42, 8'h3D, 2, 8'h00, 2, 4'b0001, 8'h00};
    run_vec(v, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
